// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between CPU and DMA with fixed CPU priority, a starvation guard and an access watchdog
module mem_bus_arbiter #(
  parameter int          MAX_CPU_STREAK = 4,
  parameter int          TIMEOUT        = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        grant_cpu_o,
  output logic        grant_dma_o,
  output logic        timeout_err_o
);
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA, ABORT} state_e;
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_CPU_STREAK);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] timer_q, timer_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic        both, pick_dma, expire, abort;
  assign both     = cpu_req_i & dma_req_i;
  assign pick_dma = dma_req_i & (~cpu_req_i | (streak_q == STREAK_MAX));
  assign expire   = (TIMEOUT != 0) && (timer_q == TIMER_LAST);
  // next state: arbitrate in IDLE, wait for memory or watchdog while granted, one ABORT cycle
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    owner_d  = owner_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (cpu_req_i | dma_req_i) begin
          state_d  = pick_dma ? GNT_DMA : GNT_CPU;
          owner_d  = pick_dma;
          streak_d = (both & ~pick_dma) ? streak_q + 4'd1 : 4'd0;
        end
      end
      GNT_CPU, GNT_DMA: begin
        state_d = mem_ready_i ? IDLE : expire ? ABORT : state_q;
        timer_d = (mem_ready_i | expire) ? 16'd0 : timer_q + 16'd1;
        err_d   = err_q | (~mem_ready_i & expire);
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous reset so mem_req drops immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      timer_q  <= '0;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
    end
  end
  assign grant_cpu_o   = state_q == GNT_CPU;
  assign grant_dma_o   = state_q == GNT_DMA;
  assign abort         = state_q == ABORT;
  assign timeout_err_o = err_q;
  assign mem_req_o     = grant_cpu_o ? cpu_req_i   : grant_dma_o ? dma_req_i   : 1'b0;
  assign mem_we_o      = grant_cpu_o ? cpu_we_i    : grant_dma_o ? dma_we_i    : 1'b0;
  assign mem_addr_o    = grant_cpu_o ? cpu_addr_i  : grant_dma_o ? dma_addr_i  : 32'h0;
  assign mem_wdata_o   = grant_cpu_o ? cpu_wdata_i : grant_dma_o ? dma_wdata_i : 32'h0;
  assign cpu_ready_o   = (grant_cpu_o & mem_ready_i) | (abort & ~owner_q);
  assign dma_ready_o   = (grant_dma_o & mem_ready_i) | (abort & owner_q);
  assign cpu_rdata_o   = abort ? ERR_DATA : mem_rdata_i;
  assign dma_rdata_o   = abort ? ERR_DATA : mem_rdata_i;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic checked against a behavioural arbiter model
module tb_mem_bus_arbiter;
  localparam int TO = 8;
  localparam int MAXS = 4;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, mem_ready = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [31:0] cpu_rdata_o, dma_rdata_o, mem_addr_o, mem_wdata_o;
  logic cpu_ready_o, dma_ready_o, mem_req_o, mem_we_o, grant_cpu_o, grant_dma_o, timeout_err_o;
  int errs = 0, checks = 0;
  int mcnt = 0, lat = 0, lat_fix = -1;
  bit auto_on = 0, rd_fix_en = 0, cpu_done = 0, dma_done = 0;
  int got, g, n, last, gap_bad;
  logic [9:0] seq;
  // behavioural model: busy 0=free, 1=serving who (0 cpu, 1 dma), 2=error reply
  int busy = 0, waited = 0, cpu_run = 0;
  bit who = 0, m_err = 0;
  wire m_pick = dma_req && (!cpu_req || cpu_run == MAXS);

  mem_bus_arbiter #(.MAX_CPU_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata_o), .dma_ready_o(dma_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .grant_cpu_o(grant_cpu_o), .grant_dma_o(grant_dma_o), .timeout_err_o(timeout_err_o));

  initial forever #5 clk = ~clk;

  function automatic logic [134:0] outs();
    return {grant_cpu_o, grant_dma_o, timeout_err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
            cpu_ready_o, dma_ready_o, cpu_rdata_o, dma_rdata_o};
  endfunction

  task automatic chk(input string nm, input logic [134:0] act, input logic [134:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 0; who <= 0; waited <= 0; cpu_run <= 0; m_err <= 0;
    end else if (busy == 0) begin
      if (cpu_req || dma_req) begin
        busy <= 1; who <= m_pick; waited <= 0;
        cpu_run <= (cpu_req && dma_req && !m_pick) ? cpu_run + 1 : 0;
      end
    end else if (busy == 1) begin
      if (mem_ready) busy <= 0;
      else if (waited == TO - 1) begin busy <= 2; m_err <= 1; end
      else waited <= waited + 1;
    end else busy <= 0;

  initial forever begin
    @(negedge clk);
    cpu_done = cpu_ready_o;
    dma_done = dma_ready_o;
    if (!reset) begin
      bit gc, gd, ab;
      gc = busy == 1 && !who;
      gd = busy == 1 && who;
      ab = busy == 2;
      chk("cycle_outputs", outs(), {gc, gd, m_err,
          gc ? cpu_req : gd ? dma_req : 1'b0,
          gc ? cpu_we : gd ? dma_we : 1'b0,
          gc ? cpu_addr : gd ? dma_addr : 32'h0,
          gc ? cpu_wdata : gd ? dma_wdata : 32'h0,
          (gc && mem_ready) || (ab && !who),
          (gd && mem_ready) || (ab && who),
          ab ? 32'hDEADBEEF : mem_rdata,
          ab ? 32'hDEADBEEF : mem_rdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_on) begin
      if (cpu_req) begin
        if (cpu_done) begin cpu_req = $urandom % 2; cpu_we = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom; end
        else if (!grant_cpu_o && $urandom % 16 == 0) cpu_req = 0;
      end else if ($urandom % 3 == 0) begin cpu_req = 1; cpu_we = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom; end
      if (dma_req) begin
        if (dma_done) begin dma_req = $urandom % 2; dma_we = $urandom; dma_addr = $urandom; dma_wdata = $urandom; end
        else if (!grant_dma_o && $urandom % 16 == 0) dma_req = 0;
      end else if ($urandom % 3 == 0) begin dma_req = 1; dma_we = $urandom; dma_addr = $urandom; dma_wdata = $urandom; end
    end
    #1;
    if (mem_req_o) begin
      if (mcnt == 0) lat = lat_fix >= 0 ? lat_fix : $urandom_range(0, 9);
      mem_ready = mcnt == lat;
      mcnt++;
    end else begin
      mcnt = 0;
      mem_ready = auto_on ? ($urandom % 4 == 0) : 1'b0;
    end
    mem_rdata = (mem_ready && rd_fix_en) ? 32'h12345678 : $urandom;
  endtask

  initial begin
    #1;
    chk("reset_values", outs(), 135'h0);
    repeat (2) @(posedge clk);
    #3 reset = 0;
    step();
    // CPU read of 0x100 with two wait cycles
    lat_fix = 2; rd_fix_en = 1;
    cpu_we = 0; cpu_addr = 32'h100; cpu_req = 1;
    step(); #2;
    chk("t1_grant", 135'({grant_cpu_o, mem_req_o, mem_we_o, mem_addr_o}), 135'({3'b110, 32'h100}));
    step(); #2;
    chk("t1_wait", 135'({cpu_ready_o, dma_ready_o}), 135'(0));
    step(); #2;
    chk("t1_done", 135'({cpu_ready_o, dma_ready_o, cpu_rdata_o}), 135'({2'b10, 32'h12345678}));
    step(); cpu_req = 0; #2;
    chk("t1_idle", 135'({grant_cpu_o, grant_dma_o, mem_req_o, dma_ready_o}), 135'(0));
    // completion exactly on the last watchdog cycle
    lat_fix = 7; cpu_addr = 32'h104; cpu_req = 1; got = 0; g = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      step(); #2;
      g += int'(grant_cpu_o);
      if (cpu_ready_o) begin
        got = 1;
        chk("t5_done", 135'({cpu_rdata_o, timeout_err_o}), 135'({32'h12345678, 1'b0}));
      end
    end
    chk("t5_seen", 135'(got), 135'(1));
    chk("t5_len", 135'(g), 135'(TO));
    step(); cpu_req = 0; #2;
    chk("t5_noabort", 135'({grant_cpu_o, cpu_ready_o, timeout_err_o}), 135'(0));
    // both held continuously, zero-wait memory: four CPU wins then DMA
    lat_fix = 0; rd_fix_en = 0; cpu_req = 1; dma_req = 1; dma_we = 0;
    n = 0; last = -1; gap_bad = 0; seq = 0;
    for (int i = 1; i <= 20; i++) begin
      step(); #2;
      if (cpu_ready_o || dma_ready_o) begin
        if (n < 10) seq[n] = dma_ready_o;
        if (last >= 0 && i - last != 2) gap_bad++;
        last = i; n++;
      end
    end
    cpu_req = 0; dma_req = 0;
    chk("t2_order", 135'(seq), 135'(10'b1000010000));
    chk("t2_count", 135'(n), 135'(10));
    chk("t2_gap", 135'(gap_bad), 135'(0));
    step();
    // DMA write with a CPU request arriving mid-grant
    lat_fix = 3; dma_we = 1; dma_addr = 32'h2000; dma_wdata = 32'hCAFEF00D; dma_req = 1;
    step(); cpu_we = 0; cpu_addr = 32'h300; cpu_req = 1; #2;
    chk("t3_write", 135'({grant_dma_o, mem_we_o, mem_addr_o, mem_wdata_o}), 135'({2'b11, 32'h2000, 32'hCAFEF00D}));
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin step(); #2; got = int'(dma_ready_o); end
    chk("t3_dma_done", 135'(got), 135'(1));
    step(); dma_req = 0; #2;
    chk("t3_idle_gap", 135'({grant_cpu_o, grant_dma_o}), 135'(0));
    step(); #2;
    chk("t3_cpu_grant", 135'({grant_cpu_o, mem_addr_o}), 135'({1'b1, 32'h300}));
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin step(); #2; got = int'(cpu_ready_o); end
    chk("t3_cpu_done", 135'(got), 135'(1));
    step(); cpu_req = 0;
    // DMA read that never completes
    lat_fix = 255; rd_fix_en = 1; dma_we = 0; dma_addr = 32'h40; dma_req = 1; got = 0; g = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      step(); #2;
      g += int'(grant_dma_o);
      if (dma_ready_o) begin
        got = 1;
        chk("t4_abort", 135'({grant_dma_o, cpu_ready_o, timeout_err_o, dma_rdata_o}), 135'({3'b001, 32'hDEADBEEF}));
      end
    end
    chk("t4_seen", 135'(got), 135'(1));
    chk("t4_len", 135'(g), 135'(TO));
    step(); dma_req = 0; #2;
    chk("t4_sticky", 135'({timeout_err_o, grant_dma_o, dma_ready_o}), 135'(3'b100));
    lat_fix = 1; cpu_req = 1; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step(); #2;
      if (cpu_ready_o) begin
        got = 1;
        chk("t4_next", 135'({cpu_rdata_o, timeout_err_o}), 135'({32'h12345678, 1'b1}));
      end
    end
    chk("t4_next_seen", 135'(got), 135'(1));
    step(); cpu_req = 0;
    // reset in the middle of a CPU grant
    lat_fix = 255; cpu_req = 1;
    step(); #2;
    chk("t6_granted", 135'(grant_cpu_o), 135'(1));
    step(); #1 reset = 1; #1;
    chk("t6_async", 135'({mem_req_o, grant_cpu_o, timeout_err_o}), 135'(0));
    cpu_req = 0;
    @(negedge clk); #2 reset = 0;
    step(); lat_fix = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h80;
    step(); #2;
    chk("t6_dma_grant", 135'({grant_dma_o, mem_req_o, mem_addr_o}), 135'({2'b11, 32'h80}));
    step(); dma_req = 0;
    step();
    // randomized traffic, every cycle checked by the model
    lat_fix = -1; rd_fix_en = 0; auto_on = 1;
    repeat (3000) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port between the CPU load/store unit and DMA_peripheral.
- Both requesters use the same req/ready protocol: req, we, addr and wdata are held until a one-cycle ready pulse.
- Fixed CPU priority, with a starvation guard that forces a DMA grant after a run of CPU wins.
- Transaction watchdog aborts a hung memory access and returns an error word to the owner.

Parameters:
MAX_CPU_STREAK, 4, consecutive CPU grants allowed while DMA waits before DMA is forced (1..15)
TIMEOUT, 64, cycles a granted access may wait for mem_ready before abort; 0 disables the watchdog
ERR_DATA, 32'hDEAD_BEEF, rdata returned to the owner on an aborted access

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ready
cpu_we  in  1  CPU write enable
cpu_addr  in  32  CPU address
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  read data to CPU
cpu_ready  out  1  CPU access complete, one-cycle pulse
dma_req  in  1  DMA access request (connects to DMA mem_req)
dma_we  in  1  DMA write enable
dma_addr  in  32  DMA address
dma_wdata  in  32  DMA write data
dma_rdata  out  32  read data to DMA
dma_ready  out  1  DMA access complete, one-cycle pulse
mem_req  out  1  request to memory
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
mem_ready  in  1  memory access complete
grant_cpu  out  1  CPU owns the port (state GNT_CPU)
grant_dma  out  1  DMA owns the port (state GNT_DMA)
timeout_err  out  1  sticky flag, set on any watchdog abort

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state=IDLE, streak=0, timer=0, timeout_err=0.
  - Consequently mem_req/mem_we=0, mem_addr/mem_wdata=0, grants=0, readies=0.
- States: IDLE, GNT_CPU, GNT_DMA, ABORT. State is registered.
- Memory-side outputs are a combinational mux on state:
  - GNT_CPU: cpu_* signals routed to mem_*.
  - GNT_DMA: dma_* signals routed to mem_*.
  - IDLE and ABORT: mem_* all zero.
- Ready and read data:
  - cpu_ready = (GNT_CPU & mem_ready) | (ABORT & owner==CPU); dma_ready is symmetric.
  - *_rdata = mem_rdata, except ERR_DATA in ABORT. The owner bit is registered at grant.
- IDLE arbitration, decided on the requests present in that cycle:
  - Both requesting: if streak==MAX_CPU_STREAK, go to GNT_DMA and set streak=0; otherwise go to GNT_CPU and increment streak.
  - Only CPU requesting: go to GNT_CPU, streak=0.
  - Only DMA requesting: go to GNT_DMA, streak=0.
  - Neither requesting: stay in IDLE, streak unchanged.
- GNT_x:
  - timer counts cycles from 0.
  - mem_ready=1: x_ready pulses in the same cycle, next state is IDLE, timer=0.
  - TIMEOUT!=0, timer==TIMEOUT-1 and mem_ready=0: next state is ABORT and timeout_err is set.
  - mem_ready wins if it arrives in the same cycle as expiry.
- ABORT: lasts one cycle; the owner's ready pulses with ERR_DATA; then IDLE.
- Latency:
  - Request seen in IDLE at cycle n: grant and mem_req at n+1.
  - Zero-wait memory completes at n+1.
  - The next grant is at n+3 at the earliest, because of the mandatory IDLE cycle after every completion.
  - That IDLE cycle keeps a requester's stale registered req (still high in its ready cycle) from being re-granted.
- Requests that drop while not granted are ignored; there is no queueing.
- A requester must not drop req while granted. If it does, the arbiter holds the grant until mem_ready or timeout.
- mem_ready while in IDLE or ABORT is ignored.
- Reset mid-access returns to IDLE immediately; mem_req falls asynchronously.
- Widths:
  - streak is 4 bits and saturates at MAX_CPU_STREAK.
  - timer is 16 bits.

Test Plan:
1. CPU-only read of addr 0x100, memory ready after 2 wait cycles with rdata 0x12345678. Required: grant_cpu at n+1; mem_addr=0x100, mem_we=0; cpu_ready and cpu_rdata=0x12345678 at n+3; IDLE at n+4; dma_ready stays 0.
2. cpu_req and dma_req both held continuously, zero-wait memory, MAX_CPU_STREAK=4. Required: grant order CPU,CPU,CPU,CPU,DMA,CPU..., one completion every 2 cycles.
3. DMA write 0xCAFEF00D to 0x2000 concurrent with a late CPU request. Required: the CPU request arriving while GNT_DMA waits; mem_wdata=0xCAFEF00D and mem_we=1 during the DMA grant; CPU is granted only after the IDLE cycle.
4. TIMEOUT=8, DMA read with mem_ready never asserted. Required: GNT_DMA for exactly 8 cycles; ABORT cycle with dma_ready=1 and dma_rdata=0xDEADBEEF; timeout_err=1 and stays 1; next access proceeds normally.
5. mem_ready arrives exactly on timer==TIMEOUT-1. Required: normal completion, no ABORT, timeout_err stays 0.
6. Reset asserted mid-GNT_CPU. Required: mem_req=0 and grant_cpu=0 asynchronously, streak=0; after release, a new DMA request is granted at n+1.
